// File: rtl/alu_load_seq.sv
// alu_load_seq: front-end sequencer for the ALU operand/opcode registers.
// A single push-button is synchronised and debounced; each accepted press
// steers the registered switch bus into A, then B, then the opcode register,
// and the result is flagged valid once all three are loaded.
module alu_load_seq #(
  parameter int NB_DATA      = 8,
  parameter int NB_OP        = 6,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_btn,
  input  logic               i_clear,
  input  logic [NB_DATA-1:0] i_sw,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_en_a,
  output logic               o_en_b,
  output logic               o_en_op,
  output logic               o_res_valid,
  output logic [1:0]         o_state
);

  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // Low NB_OP bits form the opcode field; the remaining bits only matter
  // for the operand registers. Both fields travel on the same bus.
  localparam logic [NB_DATA-1:0] OP_MASK = NB_DATA'((64'd1 << NB_OP) - 64'd1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  logic [1:0]         sync_q;
  logic               btn_s;
  logic [NB_DATA-1:0] data_q;
  logic [NB_DATA-1:0] data_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               lvl_q;
  logic               lvl_d;
  logic               lvl_prev_q;
  logic               press_s;

  state_t             state_q;
  state_t             state_d;
  logic               en_a_q;
  logic               en_a_d;
  logic               en_b_q;
  logic               en_b_d;
  logic               en_op_q;
  logic               en_op_d;
  logic               valid_q;
  logic               valid_d;

  assign btn_s   = sync_q[1];
  assign data_d  = (i_sw & OP_MASK) | (i_sw & ~OP_MASK);
  // One-cycle pulse on the rising edge of the debounced level.
  assign press_s = lvl_q & ~lvl_prev_q;

  // Two-flop button synchroniser and one-flop switch capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      data_q <= {NB_DATA{1'b0}};
    end else begin
      sync_q <= {sync_q[0], i_btn};
      data_q <= data_d;
    end
  end

  // Debounce counter: the level flips only after DEBOUNCE_CYC mismatched cycles.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (btn_s == lvl_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = ~lvl_q;
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debounce state registers; i_clear deliberately leaves these untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= CNT_ZERO;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  // Next-state and next-output logic; clear wins over a simultaneous press.
  always_comb begin
    state_d = state_q;
    en_a_d  = 1'b0;
    en_b_d  = 1'b0;
    en_op_d = 1'b0;
    if (i_clear) begin
      state_d = WAIT_A;
    end else if (press_s) begin
      case (state_q)
        WAIT_A: begin
          state_d = WAIT_B;
          en_a_d  = 1'b1;
        end
        WAIT_B: begin
          state_d = WAIT_OP;
          en_b_d  = 1'b1;
        end
        WAIT_OP: begin
          state_d = SHOW;
          en_op_d = 1'b1;
        end
        SHOW: begin
          state_d = WAIT_A;
        end
        default: begin
          state_d = WAIT_A;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    valid_d = (state_d == SHOW);
  end

  // State and registered outputs, updated together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_A;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      en_op_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_a_q  <= en_a_d;
      en_b_q  <= en_b_d;
      en_op_q <= en_op_d;
      valid_q <= valid_d;
    end
  end

  assign o_data      = data_q;
  assign o_en_a      = en_a_q;
  assign o_en_b      = en_b_q;
  assign o_en_op     = en_op_q;
  assign o_res_valid = valid_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_alu_load_seq.sv
// Directed self-checking bench for alu_load_seq with a short debounce window.
module tb_alu_load_seq;

  localparam int NB_DATA = 8;
  localparam int DEB     = 4;

  logic               clk;
  logic               rst;
  logic               i_btn;
  logic               i_clear;
  logic [NB_DATA-1:0] i_sw;
  logic [NB_DATA-1:0] o_data;
  logic               o_en_a;
  logic               o_en_b;
  logic               o_en_op;
  logic               o_res_valid;
  logic [1:0]         o_state;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;
  int cnt_op   = 0;
  int multi_hot = 0;
  int base_a;
  int base_b;
  int base_op;

  logic [2:0] en_vec;
  assign en_vec = {o_en_op, o_en_b, o_en_a};

  alu_load_seq #(
    .NB_DATA(NB_DATA),
    .NB_OP(6),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_btn(i_btn),
    .i_clear(i_clear),
    .i_sw(i_sw),
    .o_data(o_data),
    .o_en_a(o_en_a),
    .o_en_b(o_en_b),
    .o_en_op(o_en_op),
    .o_res_valid(o_res_valid),
    .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (o_en_a)  cnt_a  <= cnt_a + 1;
    if (o_en_b)  cnt_b  <= cnt_b + 1;
    if (o_en_op) cnt_op <= cnt_op + 1;
    if ((32'(o_en_a) + 32'(o_en_b) + 32'(o_en_op)) > 32'd1) multi_hot <= multi_hot + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Clean press with exact latency checks, then a debounced release.
  task automatic press_exact(input string tag, input logic [7:0] sw,
                             input logic [2:0] exp_vec, input logic [1:0] exp_state,
                             input logic exp_valid);
    i_sw  = sw;
    i_btn = 1'b1;
    tick(DEB + 2);
    chk({tag, "_early"}, 32'(en_vec), 32'd0);
    tick(1);
    chk({tag, "_en"}, 32'(en_vec), 32'(exp_vec));
    chk({tag, "_data"}, 32'(o_data), 32'(sw));
    chk({tag, "_state"}, 32'(o_state), 32'(exp_state));
    chk({tag, "_valid"}, 32'(o_res_valid), 32'(exp_valid));
    tick(1);
    chk({tag, "_width"}, 32'(en_vec), 32'd0);
    i_btn = 1'b0;
    tick(12);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick(1);
    i_clear = 1'b0;
  endtask

  initial begin
    int runs [10] = '{1, 2, 3, 1, 3, 2, 1, 2, 3, 2};
    logic lvl;

    rst     = 1'b1;
    i_btn   = 1'b0;
    i_clear = 1'b0;
    i_sw    = 8'hA5;
    tick(3);
    chk("rst_data",  32'(o_data), 32'd0);
    chk("rst_en",    32'(en_vec), 32'd0);
    chk("rst_valid", 32'(o_res_valid), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    rst = 1'b0;

    // Single clean press loads A.
    press_exact("p3c", 8'h3C, 3'b001, 2'd1, 1'b0);
    chk("p3c_state_after", 32'(o_state), 32'd1);
    do_clear();
    chk("clr_state", 32'(o_state), 32'd0);

    // Full A -> B -> OP -> SHOW -> WAIT_A cycle.
    press_exact("pa", 8'h05, 3'b001, 2'd1, 1'b0);
    press_exact("pb", 8'h0A, 3'b010, 2'd2, 1'b0);
    press_exact("pop", 8'h20, 3'b100, 2'd3, 1'b1);
    chk("show_valid", 32'(o_res_valid), 32'd1);
    chk("show_state", 32'(o_state), 32'd3);
    press_exact("p4", 8'h77, 3'b000, 2'd0, 1'b0);

    // Bouncing input followed by a stable high level: exactly one press.
    base_a = cnt_a; base_b = cnt_b; base_op = cnt_op;
    lvl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_btn = lvl;
      tick(runs[i]);
      lvl = ~lvl;
    end
    i_btn = 1'b1;
    tick(10);
    i_btn = 1'b0;
    tick(12);
    chk("bounce_a", 32'(cnt_a - base_a), 32'd1);
    chk("bounce_b", 32'(cnt_b - base_b), 32'd0);
    chk("bounce_state", 32'(o_state), 32'd1);

    // A three-cycle glitch alone is rejected.
    base_b = cnt_b;
    i_btn = 1'b1;
    tick(3);
    i_btn = 1'b0;
    tick(12);
    chk("glitch_b", 32'(cnt_b - base_b), 32'd0);
    chk("glitch_state", 32'(o_state), 32'd1);

    // Long hold gives one press; a second press needs a release first.
    do_clear();
    base_a = cnt_a; base_b = cnt_b;
    i_btn = 1'b1;
    tick(50);
    chk("hold_a", 32'(cnt_a - base_a), 32'd1);
    chk("hold_b", 32'(cnt_b - base_b), 32'd0);
    i_btn = 1'b0;
    tick(12);
    press_exact("hold_pb", 8'h5A, 3'b010, 2'd2, 1'b0);

    // Clear on the exact press cycle in WAIT_OP wins; held button does not retrigger.
    base_op = cnt_op; base_a = cnt_a;
    i_btn = 1'b1;
    tick(DEB + 2);
    i_clear = 1'b1;
    tick(1);
    i_clear = 1'b0;
    chk("clr_press_en", 32'(en_vec), 32'd0);
    chk("clr_press_state", 32'(o_state), 32'd0);
    chk("clr_press_valid", 32'(o_res_valid), 32'd0);
    tick(10);
    chk("clr_hold_op", 32'(cnt_op - base_op), 32'd0);
    chk("clr_hold_a", 32'(cnt_a - base_a), 32'd0);
    chk("clr_hold_state", 32'(o_state), 32'd0);
    i_btn = 1'b0;
    tick(12);

    // Reset in SHOW with the button held, then one press after release.
    press_exact("r_a", 8'h11, 3'b001, 2'd1, 1'b0);
    press_exact("r_b", 8'h22, 3'b010, 2'd2, 1'b0);
    press_exact("r_op", 8'h33, 3'b100, 2'd3, 1'b1);
    i_sw  = 8'h44;
    i_btn = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst2_data",  32'(o_data), 32'd0);
    chk("rst2_en",    32'(en_vec), 32'd0);
    chk("rst2_valid", 32'(o_res_valid), 32'd0);
    chk("rst2_state", 32'(o_state), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(DEB + 2);
    chk("rst2_early", 32'(en_vec), 32'd0);
    tick(1);
    chk("rst2_en_a", 32'(en_vec), 32'd1);
    chk("rst2_pdata", 32'(o_data), 32'h44);
    tick(1);
    chk("rst2_width", 32'(en_vec), 32'd0);
    chk("rst2_state_after", 32'(o_state), 32'd1);
    i_btn = 1'b0;
    tick(12);

    chk("one_hot_enables", 32'(multi_hot), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
